// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants, ALU_OP encodings,
// the per-instruction control bundle, and instruction field widths.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;
  localparam int FUNCT_W  = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file for the decode stage.
// Ports: CLK/RST (sync, active-high, clears all entries); RS_ADR/RT_ADR
// combinational read indices returning RS_DATA/RT_DATA; WB_EN/WB_ADR/WB_DATA
// synchronous write port. Register 0 always reads 0 and is never written.
// A read of the register being written this cycle returns WB_DATA, so the
// writeback result is visible to decode without an extra cycle.
module id_regfile
  import mips_pkg::*;
#(
  parameter int RF_DEPTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_W-1:0]  RS_ADR,
  input  logic [REG_W-1:0]  RT_ADR,
  output logic [DATA_W-1:0] RS_DATA,
  output logic [DATA_W-1:0] RT_DATA,
  input  logic              WB_EN,
  input  logic [REG_W-1:0]  WB_ADR,
  input  logic [DATA_W-1:0] WB_DATA
);

  logic [DATA_W-1:0] regs [RF_DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
    end else if (WB_EN && WB_ADR != '0) begin
      regs[WB_ADR] <= WB_DATA;
    end
  end

  always_comb begin
    RS_DATA = regs[RS_ADR];
    if (RS_ADR == '0)                       RS_DATA = '0;
    else if (WB_EN && WB_ADR == RS_ADR)     RS_DATA = WB_DATA;
  end

  always_comb begin
    RT_DATA = regs[RT_ADR];
    if (RT_ADR == '0)                       RT_DATA = '0;
    else if (WB_EN && WB_ADR == RT_ADR)     RT_DATA = WB_DATA;
  end

endmodule

// File: rtl/id_decode_stage.sv
// MIPS instruction-decode stage with register file and ID/EX register.
// Inputs: CLK, RST (sync, active-high), CUR_INS/NEXT_INS_ADR from fetch,
// WB_EN/WB_ADR/WB_DATA writeback port, MEM_REG_WRITE/MEM_DST for branch
// hazard detection. Outputs: PC_SRC/BRANCH_TARGET/STALL to fetch
// (combinational) and the registered EX_* operand, index and control fields.
// BEQ and J resolve here; the instruction after a taken branch/jump is
// squashed into a bubble. Build option: define ID_BNE_EN to decode BNE.
module id_decode_stage
  import mips_pkg::*;
#(
  parameter int          RF_DEPTH = 32,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_W-1:0]   CUR_INS,
  input  logic [DATA_W-1:0]   NEXT_INS_ADR,
  input  logic                WB_EN,
  input  logic [REG_W-1:0]    WB_ADR,
  input  logic [DATA_W-1:0]   WB_DATA,
  input  logic                MEM_REG_WRITE,
  input  logic [REG_W-1:0]    MEM_DST,
  output logic                PC_SRC,
  output logic [DATA_W-1:0]   BRANCH_TARGET,
  output logic                STALL,
  output logic [DATA_W-1:0]   EX_RS_DATA,
  output logic [DATA_W-1:0]   EX_RT_DATA,
  output logic [DATA_W-1:0]   EX_IMM,
  output logic [REG_W-1:0]    EX_RS,
  output logic [REG_W-1:0]    EX_RT,
  output logic [REG_W-1:0]    EX_RD,
  output logic [FUNCT_W-1:0]  EX_FUNCT,
  output logic                EX_REG_WRITE,
  output logic                EX_MEM_READ,
  output logic                EX_MEM_WRITE,
  output logic                EX_MEM_TO_REG,
  output logic                EX_ALU_SRC,
  output logic                EX_REG_DST,
  output logic [1:0]          EX_ALU_OP
);

  // ---- p0: decode of the effective instruction ----
  logic                squash_q;
  logic [DATA_W-1:0]   ins_p0;
  logic [OPCODE_W-1:0] op_p0;
  logic [REG_W-1:0]    rs_p0, rt_p0, rd_p0;
  logic [IMM_W-1:0]    imm16_p0;
  logic [TARGET_W-1:0] tgt_p0;
  logic [FUNCT_W-1:0]  funct_p0;
  logic [DATA_W-1:0]   imm_ext_p0, br_off_p0;
  logic [DATA_W-1:0]   rs_data_p0, rt_data_p0;
  ctrl_t               ctrl_p0;
  logic                is_beq_p0, is_bne_p0, is_j_p0, is_branch_p0, uses_rt_p0;
  logic                load_use_p0, br_haz_p0, take_p0;
  logic [REG_W-1:0]    ex_dst;

  assign ins_p0     = squash_q ? NOP_INS : CUR_INS;
  assign op_p0      = ins_p0[31:26];
  assign rs_p0      = ins_p0[25:21];
  assign rt_p0      = ins_p0[20:16];
  assign rd_p0      = ins_p0[15:11];
  assign imm16_p0   = ins_p0[15:0];
  assign tgt_p0     = ins_p0[25:0];
  assign funct_p0   = ins_p0[5:0];
  assign imm_ext_p0 = {{(DATA_W-IMM_W){imm16_p0[IMM_W-1]}}, imm16_p0};
  assign br_off_p0  = {imm_ext_p0[DATA_W-3:0], 2'b00};

  always_comb begin
    ctrl_p0   = '0;
    is_beq_p0 = 1'b0;
    is_bne_p0 = 1'b0;
    is_j_p0   = 1'b0;
    case (op_p0)
      OP_RTYPE: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.reg_dst   = 1'b1;
        ctrl_p0.alu_op    = ALU_FUNCT;
      end
      OP_ADDI: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
      end
      OP_LW: begin
        ctrl_p0.reg_write  = 1'b1;
        ctrl_p0.mem_read   = 1'b1;
        ctrl_p0.mem_to_reg = 1'b1;
        ctrl_p0.alu_src    = 1'b1;
      end
      OP_SW: begin
        ctrl_p0.mem_write = 1'b1;
        ctrl_p0.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        ctrl_p0.alu_op = ALU_SUB;
        is_beq_p0      = 1'b1;
      end
`ifdef ID_BNE_EN
      OP_BNE: begin
        ctrl_p0.alu_op = ALU_SUB;
        is_bne_p0      = 1'b1;
      end
`endif
      OP_J:    is_j_p0 = 1'b1;
      default: ;
    endcase
  end

  assign is_branch_p0 = is_beq_p0 | is_bne_p0;
  assign uses_rt_p0   = (op_p0 == OP_RTYPE) || (op_p0 == OP_SW) || is_branch_p0;

  id_regfile #(.RF_DEPTH(RF_DEPTH)) u_regfile (
    .CLK     (CLK),
    .RST     (RST),
    .RS_ADR  (rs_p0),
    .RT_ADR  (rt_p0),
    .RS_DATA (rs_data_p0),
    .RT_DATA (rt_data_p0),
    .WB_EN   (WB_EN),
    .WB_ADR  (WB_ADR),
    .WB_DATA (WB_DATA)
  );

  assign ex_dst = EX_REG_DST ? EX_RD : EX_RT;

  assign load_use_p0 = EX_MEM_READ && (EX_RT != '0) &&
                       ((EX_RT == rs_p0) || (uses_rt_p0 && EX_RT == rt_p0));

  // Branches compare in ID, so any producer still in EX or MEM must drain first.
  assign br_haz_p0 = is_branch_p0 &&
    ((EX_REG_WRITE && ex_dst != '0 && (ex_dst == rs_p0 || ex_dst == rt_p0)) ||
     (MEM_REG_WRITE && MEM_DST != '0 && (MEM_DST == rs_p0 || MEM_DST == rt_p0)));

  assign take_p0 = (is_beq_p0 && (rs_data_p0 == rt_data_p0)) ||
                   (is_bne_p0 && (rs_data_p0 != rt_data_p0)) ||
                   is_j_p0;

  // The squashed slot is dead, so it must neither hold fetch nor redirect it.
  assign STALL  = !RST && !squash_q && (load_use_p0 || br_haz_p0);
  assign PC_SRC = !RST && !squash_q && !STALL && take_p0;

  assign BRANCH_TARGET = is_j_p0 ? {NEXT_INS_ADR[31:28], tgt_p0, 2'b00}
                                 : NEXT_INS_ADR + br_off_p0;

  // ---- p1: ID/EX pipeline register ----
  // Stalls and squashes both issue a bubble; data fields only advance when
  // the instruction itself advances.
  always_ff @(posedge CLK) begin
    if (RST) begin
      squash_q      <= 1'b0;
      EX_RS_DATA    <= '0;
      EX_RT_DATA    <= '0;
      EX_IMM        <= '0;
      EX_RS         <= '0;
      EX_RT         <= '0;
      EX_RD         <= '0;
      EX_FUNCT      <= '0;
      EX_REG_WRITE  <= 1'b0;
      EX_MEM_READ   <= 1'b0;
      EX_MEM_WRITE  <= 1'b0;
      EX_MEM_TO_REG <= 1'b0;
      EX_ALU_SRC    <= 1'b0;
      EX_REG_DST    <= 1'b0;
      EX_ALU_OP     <= 2'b00;
    end else begin
      squash_q <= PC_SRC;
      if (STALL || squash_q) begin
        EX_REG_WRITE  <= 1'b0;
        EX_MEM_READ   <= 1'b0;
        EX_MEM_WRITE  <= 1'b0;
        EX_MEM_TO_REG <= 1'b0;
        EX_ALU_SRC    <= 1'b0;
        EX_REG_DST    <= 1'b0;
        EX_ALU_OP     <= 2'b00;
      end else begin
        EX_REG_WRITE  <= ctrl_p0.reg_write;
        EX_MEM_READ   <= ctrl_p0.mem_read;
        EX_MEM_WRITE  <= ctrl_p0.mem_write;
        EX_MEM_TO_REG <= ctrl_p0.mem_to_reg;
        EX_ALU_SRC    <= ctrl_p0.alu_src;
        EX_REG_DST    <= ctrl_p0.reg_dst;
        EX_ALU_OP     <= ctrl_p0.alu_op;
      end
      if (!STALL) begin
        EX_RS_DATA <= rs_data_p0;
        EX_RT_DATA <= rt_data_p0;
        EX_IMM     <= imm_ext_p0;
        EX_RS      <= rs_p0;
        EX_RT      <= rt_p0;
        EX_RD      <= rd_p0;
        EX_FUNCT   <= funct_p0;
      end
    end
  end

endmodule
